// File: rtl/systolic_skew_feeder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : systolic_pkg                                                   |
// | Purpose : Shared defaults, FSM state encoding and sizing helper for the  |
// |           systolic skew feeder and its buffer.                           |
// | Ports   : n/a                                                            |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package systolic_pkg;

  localparam int DEF_DATAWITH   = 16;
  localparam int DEF_ARRAY_SIZE = 2;
  localparam int DEF_DEPTH      = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_STREAM    = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_WAIT_DONE = 3'd4
  } state_e;

  // Address width for a DEPTH-entry buffer; never narrower than one bit.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_skew_feeder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : systolic_skew_feeder_if                                      |
// | Purpose   : Groups the upstream beat handshake and the PE-array side     |
// |             signals of the skew feeder.                                  |
// | Signals   : in_valid/in_ready/in_last  beat handshake                    |
// |             in_data/in_weight          one A column / B row per beat     |
// |             data_out/weight_out        skewed lanes to the array         |
// |             systolic_en/read_all_data  array control                     |
// |             compute_done               sticky done from the array        |
// |             busy                       feeder not idle                   |
// | Modports  : slave (feeder side), master (environment side)               |
// | Rev       : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
interface systolic_skew_feeder_if
  import systolic_pkg::*;
#(
  parameter int DATAWITH   = DEF_DATAWITH,
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE
);

  logic                           in_valid;
  logic                           in_ready;
  logic                           in_last;
  logic [ARRAY_SIZE*DATAWITH-1:0] in_data;
  logic [ARRAY_SIZE*DATAWITH-1:0] in_weight;
  logic [ARRAY_SIZE*DATAWITH-1:0] data_out;
  logic [ARRAY_SIZE*DATAWITH-1:0] weight_out;
  logic                           systolic_en;
  logic                           read_all_data;
  logic                           compute_done;
  logic                           busy;

  modport slave (
    input  in_valid, in_last, in_data, in_weight, compute_done,
    output in_ready, data_out, weight_out, systolic_en, read_all_data, busy
  );

  modport master (
    output in_valid, in_last, in_data, in_weight, compute_done,
    input  in_ready, data_out, weight_out, systolic_en, read_all_data, busy
  );

endinterface
`default_nettype wire

// File: rtl/systolic_skew_feeder_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : feeder_buf                                                     |
// | Purpose : Per-lane DEPTH-entry register file holding one tile of data    |
// |           and weights. One shared write port, one read port per lane.    |
// | Ports   : clk          clock                                             |
// |           wr_en_i      write strobe (all lanes)                          |
// |           wr_idx_i     write index                                       |
// |           wr_data_i    packed lane data to store                         |
// |           wr_weight_i  packed lane weights to store                      |
// |           rd_idx_i     packed per-lane read indices                      |
// |           rd_data_o    packed per-lane read data (combinational)         |
// |           rd_weight_o  packed per-lane read weights (combinational)      |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module feeder_buf
  import systolic_pkg::*;
#(
  parameter int DATAWITH   = DEF_DATAWITH,
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  wire logic                                clk,
  input  wire logic                                wr_en_i,
  input  wire logic [idx_w(DEPTH)-1:0]             wr_idx_i,
  input  wire logic [ARRAY_SIZE*DATAWITH-1:0]      wr_data_i,
  input  wire logic [ARRAY_SIZE*DATAWITH-1:0]      wr_weight_i,
  input  wire logic [ARRAY_SIZE*idx_w(DEPTH)-1:0]  rd_idx_i,
  output logic      [ARRAY_SIZE*DATAWITH-1:0]      rd_data_o,
  output logic      [ARRAY_SIZE*DATAWITH-1:0]      rd_weight_o
);

  localparam int AW = idx_w(DEPTH);

  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    logic [DATAWITH-1:0] data_mem_q   [DEPTH];
    logic [DATAWITH-1:0] weight_mem_q [DEPTH];

    // Storage is fully overwritten before being read in each tile, so it
    // carries no reset.
    always_ff @(posedge clk) begin
      if (wr_en_i) begin
        data_mem_q[wr_idx_i]   <= wr_data_i[i*DATAWITH +: DATAWITH];
        weight_mem_q[wr_idx_i] <= wr_weight_i[i*DATAWITH +: DATAWITH];
      end
    end

    assign rd_data_o[i*DATAWITH +: DATAWITH]   = data_mem_q[rd_idx_i[i*AW +: AW]];
    assign rd_weight_o[i*DATAWITH +: DATAWITH] = weight_mem_q[rd_idx_i[i*AW +: AW]];
  end

endmodule
`default_nettype wire

// File: rtl/systolic_skew_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : systolic_skew_feeder                                           |
// | Purpose : Buffers one tile of K beats (A columns / B rows) and replays   |
// |           them into a systolic PE array with lane i delayed by i         |
// |           cycles, zero-padded, then drains and waits for compute_done.   |
// | Ports   : clk   clock                                                    |
// |           rst   synchronous active-low reset                             |
// |           bus   systolic_skew_feeder_if.slave (handshake + array side)   |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int DATAWITH   = DEF_DATAWITH,
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int DEPTH      = DEF_DEPTH
) (
  input wire logic              clk,
  input wire logic              rst,
  systolic_skew_feeder_if.slave bus
);

  localparam int AW = idx_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(DEPTH + ARRAY_SIZE) + 1;
  localparam int LW = ARRAY_SIZE * DATAWITH;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   k_q, k_d;
  logic [SW-1:0]   s_q, s_d;
  logic [LW-1:0]   data_out_q, data_out_d;
  logic [LW-1:0]   weight_out_q, weight_out_d;

  logic                  w_xfer;
  logic [AW-1:0]         w_wr_idx;
  logic [CW-1:0]         w_cnt_inc;
  logic [SW-1:0]         w_stream_end;
  logic [SW-1:0]         w_s_nxt;
  logic [CW-1:0]         w_k_nxt;
  logic [ARRAY_SIZE*AW-1:0] w_rd_idx;
  logic [LW-1:0]         w_rd_data;
  logic [LW-1:0]         w_rd_weight;

  assign bus.in_ready = (state_q == ST_IDLE) ||
                        ((state_q == ST_LOAD) && (count_q < CW'(DEPTH)));
  assign w_xfer       = bus.in_valid && bus.in_ready;

  // IDLE always writes slot 0 regardless of any stale count.
  assign w_wr_idx     = (state_q == ST_IDLE) ? '0 : count_q[AW-1:0];
  assign w_cnt_inc    = (state_q == ST_IDLE) ? CW'(1) : count_q + CW'(1);

  // Last STREAM index is K+ARRAY_SIZE-2.
  assign w_stream_end = SW'(k_q) + SW'(ARRAY_SIZE) - SW'(2);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    k_d     = k_q;
    s_d     = s_q;
    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (w_xfer) begin
          count_d = w_cnt_inc;
          if (bus.in_last || (w_cnt_inc == CW'(DEPTH))) begin
            k_d     = w_cnt_inc;
            s_d     = '0;
            state_d = ST_STREAM;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_STREAM: begin
        if (s_q == w_stream_end) begin
          s_d     = '0;
          state_d = ST_DRAIN;
        end else begin
          s_d = s_q + SW'(1);
        end
      end
      ST_DRAIN: begin
        // The stream counter is reused to time the drain window.
        if (s_q == SW'(2*ARRAY_SIZE - 1)) begin
          s_d     = '0;
          state_d = ST_WAIT_DONE;
        end else begin
          s_d = s_q + SW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (bus.compute_done) begin
          count_d = '0;
          k_d     = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The output registers are loaded with the values for the cycle being
  // entered, so look ahead to the next stream index and tile length.
  assign w_s_nxt = (state_q == ST_STREAM) ? (s_q + SW'(1)) : '0;
  assign w_k_nxt = (state_q == ST_STREAM) ? k_q : k_d;

  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_skew
    logic [SW-1:0] w_off;
    logic          w_hit;
    logic          w_fwd;

    assign w_off = w_s_nxt - SW'(i);
    assign w_hit = (state_d == ST_STREAM) && (w_s_nxt >= SW'(i)) &&
                   (w_off < SW'(w_k_nxt));
    assign w_rd_idx[i*AW +: AW] = w_off[AW-1:0];

    // A single-beat tile reads slot 0 on the very edge that writes it, so
    // the incoming beat is forwarded around the buffer.
    assign w_fwd = w_xfer && (w_wr_idx == w_off[AW-1:0]);

    assign data_out_d[i*DATAWITH +: DATAWITH] =
      !w_hit ? '0 :
      w_fwd  ? bus.in_data[i*DATAWITH +: DATAWITH] :
               w_rd_data[i*DATAWITH +: DATAWITH];
    assign weight_out_d[i*DATAWITH +: DATAWITH] =
      !w_hit ? '0 :
      w_fwd  ? bus.in_weight[i*DATAWITH +: DATAWITH] :
               w_rd_weight[i*DATAWITH +: DATAWITH];
  end

  feeder_buf #(
    .DATAWITH   (DATAWITH),
    .ARRAY_SIZE (ARRAY_SIZE),
    .DEPTH      (DEPTH)
  ) u_buf (
    .clk         (clk),
    .wr_en_i     (w_xfer),
    .wr_idx_i    (w_wr_idx),
    .wr_data_i   (bus.in_data),
    .wr_weight_i (bus.in_weight),
    .rd_idx_i    (w_rd_idx),
    .rd_data_o   (w_rd_data),
    .rd_weight_o (w_rd_weight)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      k_q          <= '0;
      s_q          <= '0;
      data_out_q   <= '0;
      weight_out_q <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      k_q          <= k_d;
      s_q          <= s_d;
      data_out_q   <= data_out_d;
      weight_out_q <= weight_out_d;
    end
  end

  assign bus.data_out      = data_out_q;
  assign bus.weight_out    = weight_out_q;
  assign bus.systolic_en   = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
  assign bus.read_all_data = (state_q == ST_DRAIN) || (state_q == ST_WAIT_DONE);
  assign bus.busy          = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_systolic_skew_feeder                                        |
// | Purpose : Scoreboard bench for systolic_skew_feeder. Expected skewed     |
// |           lanes are pushed when a tile is driven and popped by a monitor |
// |           on every STREAM cycle.                                         |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_systolic_skew_feeder;

  localparam int W  = 16;
  localparam int AS = 2;
  localparam int D  = 8;
  localparam int LW = AS * W;

  typedef struct packed {
    logic [LW-1:0] d;
    logic [LW-1:0] w;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  systolic_skew_feeder_if #(.DATAWITH(W), .ARRAY_SIZE(AS)) bus ();

  systolic_skew_feeder #(.DATAWITH(W), .ARRAY_SIZE(AS), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t          sb_q[$];
  int            str_len_q[$];
  int            en_len_q[$];
  logic [LW-1:0] tile_d [D];
  logic [LW-1:0] tile_w [D];

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;
  int str_len = 0;
  int en_len = 0;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Monitor: STREAM is the only state with systolic_en=1 and read_all_data=0.
  always @(negedge clk) begin
    exp_t e;
    int   xs, xe;
    if (!mon_en) begin
      str_len = 0;
      en_len  = 0;
    end else begin
      if (bus.systolic_en && !bus.read_all_data) begin
        if (sb_q.size() == 0) begin
          chk_eq("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk_eq("data_out", 64'(bus.data_out), 64'(e.d));
          chk_eq("weight_out", 64'(bus.weight_out), 64'(e.w));
        end
        str_len++;
      end else begin
        chk_eq("data_out_zero", 64'(bus.data_out), 64'd0);
        chk_eq("weight_out_zero", 64'(bus.weight_out), 64'd0);
      end
      if (bus.systolic_en) begin
        en_len++;
      end else if (en_len != 0) begin
        if (str_len_q.size() == 0) begin
          chk_eq("len_underflow", 64'd1, 64'd0);
        end else begin
          xs = str_len_q.pop_front();
          xe = en_len_q.pop_front();
          chk_eq("stream_len", 64'(str_len), 64'(xs));
          chk_eq("en_len", 64'(en_len), 64'(xe));
        end
        str_len = 0;
        en_len  = 0;
      end
    end
  end

  // Builds the expected skew table from tile_d/tile_w, then drives k beats.
  task automatic send_tile(input int k, input bit use_last, input bit gaps);
    exp_t e;
    int   idx;
    int   guard;
    for (int s = 0; s < k + AS - 1; s++) begin
      e = '0;
      for (int i = 0; i < AS; i++) begin
        idx = s - i;
        if (idx >= 0 && idx < k) begin
          e.d[i*W +: W] = tile_d[idx][i*W +: W];
          e.w[i*W +: W] = tile_w[idx][i*W +: W];
        end
      end
      sb_q.push_back(e);
    end
    str_len_q.push_back(k + AS - 1);
    en_len_q.push_back(k + AS - 1 + 2*AS);
    for (int b = 0; b < k; b++) begin
      bus.in_valid  = 1'b1;
      bus.in_data   = tile_d[b];
      bus.in_weight = tile_w[b];
      bus.in_last   = use_last && (b == k - 1);
      guard = 0;
      while (!bus.in_ready && guard < 50) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 50) chk_eq("in_ready_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      if (gaps && b != k - 1) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic finish_tile(input int hold);
    int guard = 0;
    while (!(bus.read_all_data && !bus.systolic_en) && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) chk_eq("wait_done_timeout", 64'd0, 64'd1);
    for (int h = 0; h < hold; h++) begin
      chk_eq("wait_busy", 64'(bus.busy), 64'd1);
      chk_eq("wait_rad", 64'(bus.read_all_data), 64'd1);
      chk_eq("wait_en", 64'(bus.systolic_en), 64'd0);
      @(posedge clk); #1;
    end
    bus.compute_done = 1'b1;
    @(posedge clk); #1;
    bus.compute_done = 1'b0;
    chk_eq("idle_ready", 64'(bus.in_ready), 64'd1);
    chk_eq("idle_busy", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int guard;
    int k;
    rst              = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_last      = 1'b0;
    bus.in_data      = '0;
    bus.in_weight    = '0;
    bus.compute_done = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_data_out", 64'(bus.data_out), 64'd0);
    chk_eq("rst_weight_out", 64'(bus.weight_out), 64'd0);
    chk_eq("rst_en", 64'(bus.systolic_en), 64'd0);
    chk_eq("rst_rad", 64'(bus.read_all_data), 64'd0);
    chk_eq("rst_busy", 64'(bus.busy), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_eq("rst_ready", 64'(bus.in_ready), 64'd1);
    mon_en = 1'b1;

    // K=2 tile: lane0 in low half, lane1 in high half
    tile_d[0] = {16'd3, 16'd1};
    tile_d[1] = {16'd4, 16'd2};
    tile_w[0] = {16'd7, 16'd5};
    tile_w[1] = {16'd8, 16'd6};
    send_tile(2, 1'b1, 1'b0);
    finish_tile(0);

    // K=1 tile; compute_done held high throughout must not shorten anything
    tile_d[0] = {16'd9, 16'd9};
    tile_w[0] = {16'd9, 16'd9};
    bus.compute_done = 1'b1;
    send_tile(1, 1'b1, 1'b0);
    guard = 0;
    while (bus.busy && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) chk_eq("k1_idle_timeout", 64'd0, 64'd1);
    bus.compute_done = 1'b0;
    chk_eq("k1_ready", 64'(bus.in_ready), 64'd1);

    // Full tile: 8 beats, no in_last; a 9th beat is then offered
    for (int b = 0; b < D; b++) begin
      tile_d[b] = {16'(16'h100 + b), 16'(16'h10 + b)};
      tile_w[b] = {16'(16'h300 + b), 16'(16'h20 + b)};
    end
    send_tile(D, 1'b0, 1'b0);
    chk_eq("full_ready", 64'(bus.in_ready), 64'd0);
    bus.in_valid  = 1'b1;
    bus.in_data   = {16'hDEAD, 16'hBEEF};
    bus.in_weight = {16'hCAFE, 16'hF00D};
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk_eq("ninth_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid = 1'b0;
    finish_tile(10);

    // Backpressure: gaps between beats, K=3
    tile_d[0] = {16'hA1, 16'h11};
    tile_d[1] = {16'hA2, 16'h12};
    tile_d[2] = {16'hA3, 16'h13};
    tile_w[0] = {16'hB1, 16'h21};
    tile_w[1] = {16'hB2, 16'h22};
    tile_w[2] = {16'hB3, 16'h23};
    send_tile(3, 1'b1, 1'b1);
    finish_tile(2);

    // Random tiles
    for (int r = 0; r < 3; r++) begin
      k = $urandom_range(1, D);
      for (int b = 0; b < k; b++) begin
        tile_d[b] = LW'($urandom);
        tile_w[b] = LW'($urandom);
      end
      send_tile(k, 1'b1, r[0]);
      finish_tile(1);
    end

    // Reset during STREAM cycle s=1
    tile_d[0] = {16'h55, 16'h44};
    tile_d[1] = {16'h77, 16'h66};
    tile_w[0] = {16'h99, 16'h88};
    tile_w[1] = {16'hBB, 16'hAA};
    send_tile(2, 1'b1, 1'b0);
    @(posedge clk); #1;
    mon_en = 1'b0;
    rst    = 1'b0;
    @(posedge clk); #1;
    chk_eq("mid_rst_data", 64'(bus.data_out), 64'd0);
    chk_eq("mid_rst_weight", 64'(bus.weight_out), 64'd0);
    chk_eq("mid_rst_en", 64'(bus.systolic_en), 64'd0);
    chk_eq("mid_rst_rad", 64'(bus.read_all_data), 64'd0);
    chk_eq("mid_rst_busy", 64'(bus.busy), 64'd0);
    rst = 1'b1;
    sb_q.delete();
    str_len_q.delete();
    en_len_q.delete();
    @(posedge clk); #1;
    chk_eq("mid_rst_ready", 64'(bus.in_ready), 64'd1);
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tile_d[0] = {16'h0C, 16'h0A};
    tile_d[1] = {16'h0D, 16'h0B};
    tile_w[0] = {16'h1C, 16'h1A};
    tile_w[1] = {16'h1D, 16'h1B};
    send_tile(2, 1'b1, 1'b0);
    finish_tile(0);

    repeat (3) @(posedge clk);
    #1;
    chk_eq("sb_drained", 64'(sb_q.size()), 64'd0);
    chk_eq("len_drained", 64'(str_len_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
